// File: rtl/alu_dispatch.sv
// Issue/writeback sequencer for the registered RV32I ALU: decodes OP/OP-IMM words,
// reads operands from a 32x32 register file and writes the ALU result back to rd.
module alu_dispatch #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   output logic            alu_enable,
   output logic [2:0]      alu_funct3,
   output logic [XLEN-1:0] alu_operand_1,
   output logic [XLEN-1:0] alu_operand_2,
   input  logic [XLEN-1:0] alu_result,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] REJECT  = 2'd3;

   logic [1:0]      state;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] regs [NREGS];

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            is_op;
   logic            is_imm;
   logic            is_shift;
   logic            legal;
   logic            accept;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op2_val;

   always_comb begin
      opcode   = instr[6:0];
      funct3   = instr[14:12];
      rs1      = instr[19:15];
      rs2      = instr[24:20];
      is_op    = (opcode == 7'h33);
      is_imm   = (opcode == 7'h13);
      is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
      // funct3=2 (SLT/SLTI) is unsupported by the ALU; funct7 must be zero on OP and on shift-imm
      legal    = (funct3 != 3'd2) &&
                 ((is_op && (instr[31:25] == 7'h00)) ||
                  (is_imm && !(is_shift && (instr[31:25] != 7'h00))));
      accept   = instr_valid && instr_ready;
      rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
      rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
      op2_val  = is_op ? rs2_val : {{(XLEN-12){instr[31]}}, instr[31:20]};
      if (is_shift) begin
         op2_val[XLEN-1:5] = '0;
      end
   end

   // Operands are sampled at accept: no write can land between accept and ISSUE,
   // so this equals reading the regfile during ISSUE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         rd_q          <= '0;
         alu_funct3    <= '0;
         alu_operand_1 <= '0;
         alu_operand_2 <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rd_q <= instr[11:7];
                  if (legal) begin
                     state         <= ISSUE;
                     alu_funct3    <= funct3;
                     alu_operand_1 <= rs1_val;
                     alu_operand_2 <= op2_val;
                  end else begin
                     state <= REJECT;
                  end
               end
            end
            ISSUE: state <= CAPTURE;
            CAPTURE: begin
               if (rd_q != 5'd0) begin
                  regs[rd_q] <= alu_result;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      instr_ready = (state == IDLE);
      alu_enable  = (state == ISSUE);
      wb_valid    = (state == CAPTURE);
      illegal     = (state == REJECT);
      wb_rd       = wb_valid ? rd_q : 5'd0;
      wb_data     = wb_valid ? alu_result : '0;
      dbg_data    = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: registered ALU stub, directed program plus random
// OP/OP-IMM words checked against an architectural register-file model.
module tb_alu_dispatch;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        alu_enable;
   logic [2:0]  alu_funct3;
   logic [31:0] alu_operand_1;
   logic [31:0] alu_operand_2;
   logic [31:0] alu_result;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] model_rf [32];

   always #5 clock = ~clock;

   alu_dispatch dut (
      .clock         (clock),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .alu_enable    (alu_enable),
      .alu_funct3    (alu_funct3),
      .alu_operand_1 (alu_operand_1),
      .alu_operand_2 (alu_operand_2),
      .alu_result    (alu_result),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .illegal       (illegal),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data)
   );

   function automatic logic [31:0] rv_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a << b[4:0];
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return a >> b[4:0];
         3'd6:    return a | b;
         3'd7:    return a & b;
         default: return 32'd0;
      endcase
   endfunction

   // Registered ALU stand-in
   always_ff @(posedge clock) begin
      if (reset) alu_result <= '0;
      else if (alu_enable) alu_result <= rv_alu(alu_funct3, alu_operand_1, alu_operand_2);
   end

   // Architectural meaning of one instruction word given the model register file
   function automatic void ref_exec(input logic [31:0] ins, output bit legal,
                                    output logic [31:0] a, output logic [31:0] b,
                                    output logic [31:0] r);
      int unsigned op = ins[6:0];
      int unsigned f3 = ins[14:12];
      int unsigned f7 = ins[31:25];
      bit shift = (f3 == 1) || (f3 == 5);
      logic [11:0] imm = ins[31:20];
      legal = 0;
      if (op == 'h33 && f7 == 0 && f3 != 2) legal = 1;
      if (op == 'h13 && f3 != 2 && !(shift && f7 != 0)) legal = 1;
      a = model_rf[ins[19:15]];
      b = (op == 'h33) ? model_rf[ins[24:20]] : 32'(signed'(imm));
      if (shift) b = b % 32;
      r = rv_alu(ins[14:12], a, b);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dbg_check(input logic [4:0] addr, input string tag);
      dbg_addr = addr;
      #1;
      check(tag, dbg_data, model_rf[addr]);
   endtask

   task automatic run_instr(input logic [31:0] ins, input string tag);
      bit legal;
      logic [31:0] a, b, r;
      logic [4:0] rd = ins[11:7];
      int n = 0;
      @(negedge clock);
      while (!instr_ready && n < 10) begin
         @(negedge clock);
         n++;
      end
      check({tag, " ready"}, 32'(instr_ready), 32'd1);
      ref_exec(ins, legal, a, b, r);
      instr_valid = 1'b1;
      instr = ins;
      @(negedge clock);
      instr_valid = 1'b0;
      check({tag, " ready c1"}, 32'(instr_ready), 32'd0);
      if (legal) begin
         check({tag, " en"}, 32'(alu_enable), 32'd1);
         check({tag, " ill"}, 32'(illegal), 32'd0);
         check({tag, " f3"}, 32'(alu_funct3), 32'(ins[14:12]));
         check({tag, " op1"}, alu_operand_1, a);
         check({tag, " op2"}, alu_operand_2, b);
         @(negedge clock);
         check({tag, " wbv"}, 32'(wb_valid), 32'd1);
         check({tag, " wbrd"}, 32'(wb_rd), 32'(rd));
         check({tag, " wbdata"}, wb_data, r);
         check({tag, " en c2"}, 32'(alu_enable), 32'd0);
         if (rd != 0) model_rf[rd] = r;
         @(negedge clock);
         check({tag, " ready c3"}, 32'(instr_ready), 32'd1);
         check({tag, " wbv c3"}, 32'(wb_valid), 32'd0);
      end else begin
         check({tag, " ill"}, 32'(illegal), 32'd1);
         check({tag, " en"}, 32'(alu_enable), 32'd0);
         check({tag, " wbv"}, 32'(wb_valid), 32'd0);
         @(negedge clock);
         check({tag, " ill c2"}, 32'(illegal), 32'd0);
         check({tag, " en c2"}, 32'(alu_enable), 32'd0);
         check({tag, " ready c2"}, 32'(instr_ready), 32'd1);
      end
      dbg_check(rd, {tag, " rd"});
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd   = 5'($urandom_range(0, 31));
      logic [4:0]  rs1  = 5'($urandom_range(0, 7));
      logic [4:0]  rs2  = 5'($urandom_range(0, 7));
      logic [2:0]  f3   = 3'($urandom_range(0, 6));
      logic [11:0] imm  = 12'($urandom);
      int unsigned kind = $urandom_range(0, 9);
      if (f3 >= 3'd2) f3 = f3 + 3'd1;
      if (kind < 4) return {7'h00, rs2, rs1, f3, rd, 7'h33};
      if (kind < 8) begin
         if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = 7'h00;
         return {imm, rs1, f3, rd, 7'h13};
      end
      case ($urandom_range(0, 3))
         0:       return {7'h20, rs2, rs1, f3, rd, 7'h33};
         1:       return {imm, rs1, 3'd2, rd, 7'h13};
         2:       return {imm, rs1, f3, rd, 7'h03};
         default: return {7'h20, rs2, rs1, 3'd5, rd, 7'h13};
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      reset = 1'b1;
      instr_valid = 1'b1;
      instr = 32'h0050_0093;
      dbg_addr = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      instr_valid = 1'b0;
      #1;
      check("rst ready", 32'(instr_ready), 32'd1);
      check("rst en", 32'(alu_enable), 32'd0);
      check("rst ill", 32'(illegal), 32'd0);
      check("rst wbv", 32'(wb_valid), 32'd0);
      check("rst wbrd", 32'(wb_rd), 32'd0);
      check("rst wbdata", wb_data, 32'd0);
      check("rst f3", 32'(alu_funct3), 32'd0);
      check("rst op1", alu_operand_1, 32'd0);
      check("rst op2", alu_operand_2, 32'd0);
      for (int i = 1; i < 32; i++) dbg_check(5'(i), "rst rf");

      run_instr(32'h0050_0093, "addi x1");
      run_instr(32'hFFD0_0113, "addi x2");
      check("x2 value", model_rf[2], dbg_data);
      run_instr(32'h0020_81B3, "add x3");
      run_instr(32'h0020_92B3, "sll x5");
      run_instr(32'hFFF0_B213, "sltiu x4");
      dbg_addr = 5'd1; #1; check("x1 const", dbg_data, 32'd5);
      dbg_addr = 5'd3; #1; check("x3 const", dbg_data, 32'd2);
      dbg_addr = 5'd5; #1; check("x5 const", dbg_data, 32'hA000_0000);
      dbg_addr = 5'd4; #1; check("x4 const", dbg_data, 32'd1);
      run_instr(32'h4020_8333, "sub x6");
      run_instr(32'h0020_A333, "slt x6");
      run_instr(32'h0000_0303, "load op");
      dbg_addr = 5'd6; #1; check("x6 const", dbg_data, 32'd0);
      run_instr(32'h0070_0013, "addi x0");

      // Back-to-back: valid held high, ready must drop for exactly two cycles
      @(negedge clock);
      instr_valid = 1'b1;
      instr = 32'h0010_0413;
      for (int k = 0; k < 2; k++) begin
         low = 0;
         @(negedge clock);
         while (!instr_ready && low < 10) begin
            @(negedge clock);
            low++;
         end
         check("b2b low cycles", 32'(low), 32'd2);
         instr = 32'h0014_0493;
      end
      @(negedge clock);
      instr_valid = 1'b0;
      model_rf[8] = 32'd1;
      model_rf[9] = 32'd2;
      repeat (3) @(negedge clock);
      dbg_check(5'd8, "b2b x8");
      dbg_check(5'd9, "b2b x9");

      // Reset landing in CAPTURE wins over the writeback
      instr_valid = 1'b1;
      instr = 32'h0090_0393;
      @(negedge clock);
      instr_valid = 1'b0;
      @(negedge clock);
      check("rstcap wbv", 32'(wb_valid), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      check("rstcap ready", 32'(instr_ready), 32'd1);
      check("rstcap wbv after", 32'(wb_valid), 32'd0);
      dbg_check(5'd7, "rstcap x7");
      dbg_check(5'd1, "rstcap x1");

      for (int i = 0; i < 8; i++) run_instr({12'($urandom_range(1, 4095)), 5'd0, 3'd0, 5'(i), 7'h13},
                                            "seed");
      for (int i = 0; i < 60; i++) run_instr(rand_instr(), "rand");
      for (int i = 0; i < 32; i++) dbg_check(5'(i), "final rf");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
